videomem_rd_burst: RTL and testbench
====================================

# videomem_rd_burst

Burst read sequencer between the video-memory read requester and the SDRAM controller's Avalon-MM read port, all in the `mem_clock` domain. It accepts one burst request per `read_request`/`read_req_ack` handshake and issues a fixed-length burst read. It tracks bursts in flight and limits them to a fixed maximum, which produces `mem_ready` for the requester. Returned beats are counted and forwarded, registered, as `rdata`/`rdata_valid` to the scan-out FIFO write side.

## Interface
- `DATA_W`, 16, width of one memory word / beat
- `ADDR_W`, 25, word address width
- `BURST_LEN`, 8, beats per burst (power of two, 2..16)
- `MAX_OUTSTANDING`, 4, maximum bursts accepted but not fully returned
- `mem_clock`  in  1  sole clock; one clock, all logic on its rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `read_request`  in  1  requester wants a burst at `read_addr`
- `read_addr`  in  ADDR_W  burst start address (low log2(BURST_LEN) bits are zero)
- `read_req_ack`  out  1  slot free; a request is accepted on any cycle where `read_request && read_req_ack`
- `mem_ready`  out  1  requester may keep requesting
- `avm_read`  out  1  Avalon read command
- `avm_address`  out  ADDR_W  command address
- `avm_burstcount`  out  5  constant `BURST_LEN`
- `avm_waitrequest`  in  1  controller stalls the command
- `avm_readdatavalid`  in  1  one returned beat
- `avm_readdata`  in  DATA_W  returned beat data
- `rdata_valid`  out  1  forwarded beat strobe, to FIFO write
- `rdata`  out  DATA_W  forwarded beat data
- `outstanding`  out  3  bursts issued and not completed (width clog2(MAX_OUTSTANDING+1))
- `burst_err`  out  1  sticky: a beat arrived with no burst outstanding

## Operation
- State: `cmd_pending` (command register full), `outstanding` counter, beat counter `beat_cnt` (log2(BURST_LEN) bits), `burst_err`.
- `in_flight = outstanding + cmd_pending`.
- `read_req_ack = !cmd_pending && (in_flight < MAX_OUTSTANDING)`.
  - Depends on registered state only; never on `read_request` (no combinational loop).
- `mem_ready = (in_flight < MAX_OUTSTANDING)`.
  - The requester registers its request one cycle late, so a request may be held against a deasserted ack. It is held and accepted later; no request is ever lost or duplicated.
- Accept: on `read_request && read_req_ack`:
  - latch `read_addr` into `avm_address`;
  - set `cmd_pending`; `avm_read = cmd_pending`.
- Issue: on `avm_read && !avm_waitrequest`, clear `cmd_pending` and increment `outstanding`.
  - `avm_address` is stable while `avm_read` is high.
- Return: each `avm_readdatavalid` beat with `outstanding != 0`:
  - forward the beat;
  - increment `beat_cnt`;
  - when `beat_cnt == BURST_LEN-1`, wrap it to 0 and decrement `outstanding`.
- Issue and last-beat completion on the same edge: `outstanding` is unchanged (net zero).
- A beat with `outstanding == 0`: drop it (no `rdata_valid`) and set `burst_err`. It stays set until reset.
- `outstanding` never exceeds `MAX_OUTSTANDING` and never underflows.

## Timing
- Reset (async assert, sync release) clears all state. Output values in reset:
  - `read_req_ack` = 1, `mem_ready` = 1;
  - `avm_read` = 0, `avm_address` = 0;
  - `rdata_valid` = 0, `rdata` = 0;
  - `outstanding` = 0, `burst_err` = 0.
- Reset mid-burst abandons in-flight bursts. Beats the controller returns afterwards raise `burst_err`. The controller is reset by the same `reset_n`.
- Acceptance to `avm_read` high: 1 cycle. With no wait states, back-to-back accepts are possible every 2 cycles (ack is low while `cmd_pending`).
- `avm_readdatavalid` to `rdata_valid`: exactly 1 cycle, registered, data aligned. Sustains 1 beat/cycle indefinitely.
- `read_req_ack`/`mem_ready` reflect the counter state of the current cycle. A completing burst frees its slot on the following cycle.

## Structure
- Shared video package holds:
  - `VMEM_ADDR_W` = 25;
  - `VMEM_DATA_W` = 16;
  - `VMEM_BURST_LEN` = 8;
  - the 1280x720 frame constants shared with the requester.
- Single module, no sub-module. The beat counter and outstanding counter are small enough to stay inline.

## Test plan
- Single request `read_addr=0x000040`, no wait states:
  - ack same cycle, `avm_read` high 1 cycle later with address 0x000040, burstcount 8;
  - after 8 beats, `outstanding` returns 0 and 8 `rdata_valid` pulses occur, each 1 cycle after its beat.
- Hold `read_request` high, controller never returns data:
  - exactly 4 commands issued, then `mem_ready` = 0, `read_req_ack` = 0, `outstanding` = 4;
  - first completed burst restores `mem_ready` = 1 next cycle.
- `avm_waitrequest` high for 5 cycles during a command:
  - `avm_read` and `avm_address` held constant;
  - no second ack;
  - `outstanding` increments only on the release cycle.
- Last beat of burst A coincides with issue of burst B: `outstanding` is unchanged across that edge.
- Beat injected while `outstanding` = 0: `rdata_valid` stays 0, `burst_err` = 1 and stays set.
- Assert `reset_n` low mid-burst with 3 outstanding: all outputs go to reset values immediately; normal acceptance resumes after release.

Source files
------------

// File: rtl/videomem_rd_burst_pkg.sv
// rtl/videomem_rd_burst_pkg.sv - shared video memory constants for the requester and burst reader
package videomem_rd_burst_pkg;

  localparam int VMEM_ADDR_W    = 25;
  localparam int VMEM_DATA_W    = 16;
  localparam int VMEM_BURST_LEN = 8;

  localparam int VMEM_H_ACTIVE        = 1280;
  localparam int VMEM_V_ACTIVE        = 720;
  // One 16-bit word per pixel, so a line is H_ACTIVE words.
  localparam int VMEM_WORDS_PER_LINE  = VMEM_H_ACTIVE;
  localparam int VMEM_BURSTS_PER_LINE = VMEM_WORDS_PER_LINE / VMEM_BURST_LEN;
  localparam int VMEM_FRAME_WORDS     = VMEM_WORDS_PER_LINE * VMEM_V_ACTIVE;

  typedef logic [VMEM_ADDR_W-1:0] vmem_addr_t;

  function automatic vmem_addr_t vmem_line_base(input int unsigned line);
    return vmem_addr_t'(line * VMEM_WORDS_PER_LINE);
  endfunction

endpackage

// File: rtl/videomem_rd_burst.sv
// rtl/videomem_rd_burst.sv - fixed-length Avalon-MM burst read sequencer with in-flight limit
module videomem_rd_burst
  import videomem_rd_burst_pkg::*;
#(
  parameter int DATA_W          = VMEM_DATA_W,
  parameter int ADDR_W          = VMEM_ADDR_W,
  parameter int BURST_LEN       = VMEM_BURST_LEN,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                       mem_clock,
  input  logic                                       reset_n,
  input  logic                                       read_request,
  input  logic [ADDR_W-1:0]                          read_addr,
  output logic                                       read_req_ack,
  output logic                                       mem_ready,
  output logic                                       avm_read,
  output logic [ADDR_W-1:0]                          avm_address,
  output logic [4:0]                                 avm_burstcount,
  input  logic                                       avm_waitrequest,
  input  logic                                       avm_readdatavalid,
  input  logic [DATA_W-1:0]                          avm_readdata,
  output logic                                       rdata_valid,
  output logic [DATA_W-1:0]                          rdata,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]       outstanding,
  output logic                                       burst_err
);

  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int BEAT_W = $clog2(BURST_LEN);

  localparam logic [CNT_W:0]      MAX_OUT_L  = (CNT_W + 1)'(MAX_OUTSTANDING);
  localparam logic [BEAT_W-1:0]   LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
  localparam logic [4:0]          BURSTCOUNT = 5'(BURST_LEN);

  logic                 r_cmd_pending;
  logic [ADDR_W-1:0]    r_addr;
  logic [CNT_W-1:0]     r_outstanding;
  logic [BEAT_W-1:0]    r_beat_cnt;
  logic                 r_burst_err;
  logic                 r_rdata_valid;
  logic [DATA_W-1:0]    r_rdata;

  logic [CNT_W:0]       w_in_flight;
  logic                 w_slot_free;
  logic                 w_ack;
  logic                 w_accept;
  logic                 w_issue;
  logic                 w_beat_ok;
  logic                 w_beat_orphan;
  logic                 w_last_beat;

  // A pending command already holds a slot, so it counts against the limit.
  assign w_in_flight   = {1'b0, r_outstanding} + {{CNT_W{1'b0}}, r_cmd_pending};
  assign w_slot_free   = (w_in_flight < MAX_OUT_L);
  assign w_ack         = !r_cmd_pending && w_slot_free;
  assign w_accept      = read_request && w_ack;
  assign w_issue       = r_cmd_pending && !avm_waitrequest;
  assign w_beat_ok     = avm_readdatavalid && (r_outstanding != '0);
  assign w_beat_orphan = avm_readdatavalid && (r_outstanding == '0);
  assign w_last_beat   = w_beat_ok && (r_beat_cnt == LAST_BEAT);

  always_ff @(posedge mem_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cmd_pending <= 1'b0;
      r_addr        <= '0;
    end else if (w_accept) begin
      r_cmd_pending <= 1'b1;
      r_addr        <= read_addr;
    end else if (w_issue) begin
      r_cmd_pending <= 1'b0;
    end
  end

  always_ff @(posedge mem_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_outstanding <= '0;
    end else begin
      case ({w_issue, w_last_beat})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  always_ff @(posedge mem_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_beat_cnt <= '0;
    end else if (w_beat_ok) begin
      r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + 1'b1;
    end
  end

  // Beats with nothing outstanding are dropped and flagged until the next reset.
  always_ff @(posedge mem_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_burst_err <= 1'b0;
    end else if (w_beat_orphan) begin
      r_burst_err <= 1'b1;
    end
  end

  always_ff @(posedge mem_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata_valid <= 1'b0;
      r_rdata       <= '0;
    end else begin
      r_rdata_valid <= w_beat_ok;
      if (w_beat_ok) begin
        r_rdata <= avm_readdata;
      end
    end
  end

  assign read_req_ack   = w_ack;
  assign mem_ready      = w_slot_free;
  assign avm_read       = r_cmd_pending;
  assign avm_address    = r_addr;
  assign avm_burstcount = BURSTCOUNT;
  assign rdata_valid    = r_rdata_valid;
  assign rdata          = r_rdata;
  assign outstanding    = r_outstanding;
  assign burst_err      = r_burst_err;

endmodule

// File: tb/tb_videomem_rd_burst.sv
// tb/tb_videomem_rd_burst.sv - scoreboard bench for videomem_rd_burst
module tb_videomem_rd_burst;

  logic        mem_clock = 1'b0;
  logic        reset_n;
  logic        read_request;
  logic [24:0] read_addr;
  logic        read_req_ack;
  logic        mem_ready;
  logic        avm_read;
  logic [24:0] avm_address;
  logic [4:0]  avm_burstcount;
  logic        avm_waitrequest;
  logic        avm_readdatavalid;
  logic [15:0] avm_readdata;
  logic        rdata_valid;
  logic [15:0] rdata;
  logic [2:0]  outstanding;
  logic        burst_err;

  typedef struct {
    logic [15:0] d;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   n_fwd = 0;

  videomem_rd_burst dut (
    .mem_clock         (mem_clock),
    .reset_n           (reset_n),
    .read_request      (read_request),
    .read_addr         (read_addr),
    .read_req_ack      (read_req_ack),
    .mem_ready         (mem_ready),
    .avm_read          (avm_read),
    .avm_address       (avm_address),
    .avm_burstcount    (avm_burstcount),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdatavalid (avm_readdatavalid),
    .avm_readdata      (avm_readdata),
    .rdata_valid       (rdata_valid),
    .rdata             (rdata),
    .outstanding       (outstanding),
    .burst_err         (burst_err)
  );

  always #5 mem_clock = ~mem_clock;

  always @(posedge mem_clock) cyc <= cyc + 1;

  // Forwarded beats must match pushed data and arrive exactly one cycle after the beat.
  always @(negedge mem_clock) begin
    if (rdata_valid === 1'b1) begin
      n_fwd++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL fwd_unexpected: rdata=%h at cycle %0d, expected no beat", rdata, cyc);
      end else begin
        e = sb.pop_front();
        if (rdata !== e.d || cyc != e.due) begin
          bad++;
          $display("FAIL fwd_beat: got %h at cycle %0d, expected %h at cycle %0d", rdata, cyc, e.d, e.due);
        end
      end
    end
  end

  task automatic nxt();
    @(posedge mem_clock);
    #2;
  endtask

  task automatic send_beats(input int n, input bit fwd);
    for (int i = 0; i < n; i++) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = 16'($urandom);
      if (fwd) sb.push_back('{d: avm_readdata, due: cyc + 1});
      nxt();
    end
    avm_readdatavalid = 1'b0;
  endtask

  task automatic issue_burst(input logic [24:0] addr);
    read_request = 1'b1;
    read_addr    = addr;
    #1;
    total++;
    if (read_req_ack !== 1'b1) begin bad++; $display("FAIL issue_ack: ack=%b expected 1", read_req_ack); end
    nxt();
    read_request = 1'b0;
    total++;
    if (avm_read !== 1'b1 || avm_address !== addr) begin
      bad++; $display("FAIL issue_cmd: read=%b addr=%h expected 1 %h", avm_read, avm_address, addr);
    end
    nxt();
  endtask

  task automatic check_reset_outputs(input string tag);
    total++;
    if (read_req_ack !== 1'b1 || mem_ready !== 1'b1 || avm_read !== 1'b0 || avm_address !== 25'd0 ||
        rdata_valid !== 1'b0 || rdata !== 16'd0 || outstanding !== 3'd0 || burst_err !== 1'b0) begin
      bad++;
      $display("FAIL %s: ack=%b rdy=%b rd=%b addr=%h rv=%b rd=%h out=%0d err=%b expected 1 1 0 0 0 0 0 0",
               tag, read_req_ack, mem_ready, avm_read, avm_address, rdata_valid, rdata, outstanding, burst_err);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; read_request = 1'b0; read_addr = '0;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
    nxt(); nxt();
    check_reset_outputs("reset_values");
    total++;
    if (avm_burstcount !== 5'd8) begin bad++; $display("FAIL burstcount: got %0d expected 8", avm_burstcount); end
    reset_n = 1'b1;
    nxt();
  endtask

  task automatic test_single();
    int f0;
    issue_burst(25'h000040);
    total++;
    if (outstanding !== 3'd1 || avm_read !== 1'b0) begin
      bad++; $display("FAIL single_issue: out=%0d read=%b expected 1 0", outstanding, avm_read);
    end
    f0 = n_fwd;
    send_beats(8, 1'b1);
    nxt();
    total++;
    if (outstanding !== 3'd0) begin bad++; $display("FAIL single_done: out=%0d expected 0", outstanding); end
    total++;
    if (n_fwd - f0 != 8) begin bad++; $display("FAIL single_pulses: got %0d expected 8", n_fwd - f0); end
  endtask

  task automatic test_max_outstanding();
    int issues = 0;
    read_request = 1'b1;
    read_addr    = 25'h001000;
    for (int i = 0; i < 20; i++) begin
      if (avm_read && !avm_waitrequest) issues++;
      if (read_request && read_req_ack) read_addr = read_addr + 25'd8;
      nxt();
    end
    total++;
    if (issues != 4 || outstanding !== 3'd4 || mem_ready !== 1'b0 || read_req_ack !== 1'b0) begin
      bad++; $display("FAIL max_out: issues=%0d out=%0d rdy=%b ack=%b expected 4 4 0 0",
                      issues, outstanding, mem_ready, read_req_ack);
    end
    read_request = 1'b0;
    send_beats(8, 1'b1);
    total++;
    if (mem_ready !== 1'b1 || outstanding !== 3'd3) begin
      bad++; $display("FAIL max_release: rdy=%b out=%0d expected 1 3", mem_ready, outstanding);
    end
    send_beats(24, 1'b1);
    nxt();
    total++;
    if (outstanding !== 3'd0) begin bad++; $display("FAIL max_drain: out=%0d expected 0", outstanding); end
  endtask

  task automatic test_waitrequest();
    avm_waitrequest = 1'b1;
    read_request    = 1'b1;
    read_addr       = 25'h000100;
    nxt();
    read_addr = 25'h000200;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (avm_read !== 1'b1 || avm_address !== 25'h000100 || read_req_ack !== 1'b0 || outstanding !== 3'd0) begin
        bad++; $display("FAIL wait_hold: read=%b addr=%h ack=%b out=%0d expected 1 000100 0 0",
                        avm_read, avm_address, read_req_ack, outstanding);
      end
      nxt();
    end
    avm_waitrequest = 1'b0;
    nxt();
    total++;
    if (outstanding !== 3'd1 || avm_read !== 1'b0) begin
      bad++; $display("FAIL wait_release: out=%0d read=%b expected 1 0", outstanding, avm_read);
    end
    nxt();
    read_request = 1'b0;
    total++;
    if (avm_read !== 1'b1 || avm_address !== 25'h000200) begin
      bad++; $display("FAIL wait_held_req: read=%b addr=%h expected 1 000200", avm_read, avm_address);
    end
    nxt();
    total++;
    if (outstanding !== 3'd2) begin bad++; $display("FAIL wait_second: out=%0d expected 2", outstanding); end
    send_beats(16, 1'b1);
    nxt();
  endtask

  task automatic test_back_to_back();
    issue_burst(25'h000400);
    avm_waitrequest = 1'b1;
    read_request    = 1'b1;
    read_addr       = 25'h000408;
    nxt();
    read_request = 1'b0;
    send_beats(7, 1'b1);
    total++;
    if (outstanding !== 3'd1 || avm_read !== 1'b1) begin
      bad++; $display("FAIL overlap_pre: out=%0d read=%b expected 1 1", outstanding, avm_read);
    end
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b1;
    avm_readdata      = 16'hA5C3;
    sb.push_back('{d: avm_readdata, due: cyc + 1});
    nxt();
    avm_readdatavalid = 1'b0;
    total++;
    if (outstanding !== 3'd1 || avm_read !== 1'b0) begin
      bad++; $display("FAIL overlap_edge: out=%0d read=%b expected 1 0", outstanding, avm_read);
    end
    send_beats(8, 1'b1);
    nxt();
    total++;
    if (outstanding !== 3'd0) begin bad++; $display("FAIL overlap_drain: out=%0d expected 0", outstanding); end
  endtask

  task automatic test_orphan_beat();
    send_beats(1, 1'b0);
    total++;
    if (rdata_valid !== 1'b0 || burst_err !== 1'b1) begin
      bad++; $display("FAIL orphan: rv=%b err=%b expected 0 1", rdata_valid, burst_err);
    end
    nxt(); nxt(); nxt();
    total++;
    if (burst_err !== 1'b1) begin bad++; $display("FAIL orphan_sticky: err=%b expected 1", burst_err); end
  endtask

  task automatic test_reset_mid();
    issue_burst(25'h000500);
    issue_burst(25'h000508);
    issue_burst(25'h000510);
    total++;
    if (outstanding !== 3'd3) begin bad++; $display("FAIL mid_setup: out=%0d expected 3", outstanding); end
    send_beats(2, 1'b1);
    nxt();
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    nxt();
    reset_n = 1'b1;
    send_beats(1, 1'b0);
    total++;
    if (rdata_valid !== 1'b0 || burst_err !== 1'b1) begin
      bad++; $display("FAIL stale_beat: rv=%b err=%b expected 0 1", rdata_valid, burst_err);
    end
    issue_burst(25'h000600);
    send_beats(8, 1'b1);
    nxt();
    total++;
    if (outstanding !== 3'd0) begin bad++; $display("FAIL resume_drain: out=%0d expected 0", outstanding); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_max_outstanding();
    test_waitrequest();
    test_back_to_back();
    test_orphan_beat();
    test_reset_mid();
    nxt(); nxt();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL sb_empty: %0d beats never forwarded, expected 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
